// File: rtl/loop_iter_sched.sv
// ---------------------------------------------------------------------------
// loop_iter_sched : arms N replays of the loop buffer, counts wraps, injects STOP
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module loop_iter_sched #(
  parameter int CNT_W = 32,
  parameter int CMD_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_iters,
  output logic             cfg_ready,
  input  logic             abort,
  input  logic             looping,
  input  logic             loop_wrap,
  output logic             stop_valid,
  output logic [CMD_W-1:0] stop_instr,
  input  logic             stop_ready,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [3:0]       STOP_OPC = 4'hF;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_RUN      = 3'd2,
    S_STOP_REQ = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count;
  logic             aborted_q;
  logic             abort_pend;
  logic             abort_any;
  logic             last_iter;
  logic             counting;

  // The compare uses the pre-increment count; a same-cycle wrap is picked up next cycle.
  assign abort_any = abort | abort_pend;
  assign last_iter = (target != '0) && (count == target - CNT_ONE);
  assign counting  = (state == S_RUN) || (state == S_STOP_REQ) || (state == S_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cfg_valid)              state_nxt = S_ARMED;
      S_ARMED:    if (looping)                state_nxt = S_RUN;
      S_RUN:      if (abort_any || last_iter) state_nxt = S_STOP_REQ;
      S_STOP_REQ: if (stop_ready)             state_nxt = S_DRAIN;
      S_DRAIN:    if (!looping)               state_nxt = S_DONE;
      S_DONE:                                 state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      target     <= '0;
      count      <= '0;
      aborted_q  <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cfg_valid) begin
        target     <= cfg_iters;
        count      <= '0;
        aborted_q  <= 1'b0;
        abort_pend <= 1'b0;
      end else begin
        if (counting && loop_wrap && !(&count))
          count <= count + CNT_ONE;
        if (state == S_ARMED && abort)
          abort_pend <= 1'b1;
        if (state == S_RUN && abort_any)
          aborted_q <= 1'b1;
      end
    end
  end

  assign cfg_ready  = (state == S_IDLE);
  assign stop_valid = (state == S_STOP_REQ);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign aborted    = aborted_q;
  assign iter_count = count;
  assign stop_instr = {STOP_OPC, {(CMD_W-4){1'b0}}};

endmodule

`default_nettype wire
